usb_pkt_fault_injector: RTL
===========================

Name: usb_pkt_fault_injector

Overview:
- Synthesizable packet-level fault injector between the device-side packet encoder and the bit-level serializer (NRZI/bit-stuff) in the thumb-drive model.
- Replaces the one-shot behavioural fault tasks: garble, drop/force-timeout and NAK substitution.
- Each mode applies to a programmable number of consecutive packets.
- Exercises host retry, timeout and NAK recovery in RTL simulation and emulation.

Parameters:
CNT_W, 8, width of fault count and injected-fault counter
GARBLE_IDX, 1, byte index in a packet (PID = 0) that is corrupted in GARBLE mode
GARBLE_MASK, 8'h01, XOR mask applied to that byte

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
arm_valid  in  1  load new fault program this cycle
arm_mode  in  2  fault_mode_t: NONE=0, GARBLE=1, DROP=2, NAK=3
arm_count  in  CNT_W  number of eligible packets to fault
in_valid  in  1  input byte valid
in_data  in  8  input byte
in_sop  in  1  first byte (PID) of packet
in_eop  in  1  last byte of packet
in_ready  out  1  input accepted when in_valid & in_ready
out_valid  out  1  output byte valid
out_data  out  8  output byte
out_sop  out  1  output first byte
out_eop  out  1  output last byte
out_ready  in  1  downstream ready
faults_pending  out  CNT_W  remaining faults
faults_injected  out  CNT_W  total faults applied since reset, saturating
orphan_err  out  1  one-cycle pulse: byte without SOP arrived in IDLE

Behaviour:
- Reset: all outputs 0. State IDLE, mode NONE, pending 0, injected 0, output register empty.
- Datapath:
  - One registered output stage.
  - in_ready = !out_valid | out_ready.
  - Pass-through latency is 1 cycle.
  - Byte order and SOP/EOP are preserved.
- Arming:
  - arm_valid loads mode and count in any cycle.
  - The new program takes effect at the next accepted SOP; the packet in flight is unaffected.
  - If arm and a faulted SOP occur in the same cycle, the arm value wins and no decrement is applied.
- Eligibility, decided at the accepted SOP:
  - Requires pending > 0 and mode != NONE.
  - GARBLE is eligible only for DATA PIDs: 8'hC3 (DATA0) or 8'h4B (DATA1).
  - NAK is eligible for DATA PIDs and ACK (8'hD2).
  - DROP is eligible for any PID.
  - On an eligible SOP: pending decrements by 1 and injected increments, saturating at all-ones.
  - Ineligible packets pass untouched and leave the counters unchanged.
- FSM:
  - IDLE: on SOP, go to PASS, GARBLE, DROP or NAK_EMIT. A byte without SOP is discarded and pulses orphan_err.
  - PASS: forward bytes; EOP goes to IDLE.
  - GARBLE:
    - Forward bytes, tracking a byte index.
    - The byte at GARBLE_IDX is XORed with GARBLE_MASK.
    - If EOP comes before GARBLE_IDX, the packet passes unmodified but still counts as faulted.
    - EOP goes to IDLE.
  - DROP: in_ready=1 and out_valid stays 0 for the whole packet; EOP goes to IDLE. The host sees silence, i.e. a timeout.
  - NAK_EMIT:
    - Hold in_ready=0 until the output register is free.
    - Emit a single byte 8'h5A with sop=1, eop=1.
    - If the input SOP byte was also EOP, go to IDLE; otherwise go to DISCARD.
  - DISCARD: consume input with in_ready=1, no output; EOP goes to IDLE.
- Mid-packet SOP, in any non-IDLE state: the current packet ends.
  - In PASS/GARBLE, the previous output byte is not patched; the protocol layer sees a truncated packet.
  - The new SOP is evaluated as if in IDLE, in the same cycle.
- Backpressure: with out_ready=0, out_valid/out_data hold stable. DROP/DISCARD consume regardless of out_ready.
- Reset mid-packet: returns to IDLE, clears the program, output register emptied immediately.

Decomposition:
- usb_fault_pkg:
  - fault_mode_t enum.
  - PID constants PID_ACK=8'hD2, PID_NAK=8'h5A, PID_DATA0=8'hC3, PID_DATA1=8'h4B.
  - state_t enum.
- Sub-module usb_byte_out_reg: the 1-entry valid/ready output register, reused by the serializer.

Test Plan:
- Reset, then pass DATA0 {C3,EF,BE,AD,DE,..,crc} with mode NONE -> identical stream 1 cycle later; injected=0.
- Arm GARBLE count=1, send two DATA0 packets -> first packet byte1 = 8'hEE (EF^01), second unmodified; pending=0, injected=1.
- Arm DROP count=1, send ACK then DATA1 -> ACK absent on output (out_valid never high), DATA1 passes; pending 1->0.
- Arm NAK count=2, send three DATA0 packets of 11 bytes -> output is 5A (sop&eop), 5A, then full third packet; input fully consumed.
- Arm GARBLE count=3, send token PID 8'h69 packet -> passes, pending stays 3; arm again mid-packet with count 0 -> packet unaffected, next DATA0 passes.
- Random out_ready stalls during GARBLE, plus reset asserted mid-packet -> no byte loss/duplication before reset; all outputs 0 the cycle after reset.

Source files
------------

// File: rtl/usb_fault_pkg.sv
// Shared types and PID constants for the packet-level fault injector.
package usb_fault_pkg;

  typedef enum logic [1:0] {
    ModeNone   = 2'd0,
    ModeGarble = 2'd1,
    ModeDrop   = 2'd2,
    ModeNak    = 2'd3
  } fault_mode_t;

  typedef enum logic [2:0] {
    StIdle,
    StPass,
    StGarble,
    StDrop,
    StNakEmit,
    StDiscard
  } state_t;

  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  function automatic logic is_data_pid(input logic [7:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

endpackage

// File: rtl/usb_byte_out_reg.sv
// Single-entry valid/ready byte register with packet framing flags.
module usb_byte_out_reg (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_sop,
  input  logic       i_eop,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_sop,
  output logic       o_eop,
  output logic       o_free
);

  logic       r_valid;
  logic [7:0] r_data;
  logic       r_sop;
  logic       r_eop;

  // Caller only loads when o_free is high, so a held byte is never overwritten.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= 8'h00;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_sop   <= i_sop;
      r_eop   <= i_eop;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_sop   = r_sop;
  assign o_eop   = r_eop;
  assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/usb_pkt_fault_injector.sv
// Packet-level fault injector: garbles, drops or NAK-substitutes a programmed number
// of eligible packets between the packet encoder and the bit-level serializer.
module usb_pkt_fault_injector
  import usb_fault_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned GARBLE_IDX  = 1,
  parameter logic [7:0]  GARBLE_MASK = 8'h01
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_arm_valid,
  input  logic [1:0]       i_arm_mode,
  input  logic [CNT_W-1:0] i_arm_count,
  input  logic             i_in_valid,
  input  logic [7:0]       i_in_data,
  input  logic             i_in_sop,
  input  logic             i_in_eop,
  output logic             o_in_ready,
  output logic             o_out_valid,
  output logic [7:0]       o_out_data,
  output logic             o_out_sop,
  output logic             o_out_eop,
  input  logic             i_out_ready,
  output logic [CNT_W-1:0] o_faults_pending,
  output logic [CNT_W-1:0] o_faults_injected,
  output logic             o_orphan_err
);

  localparam logic [7:0]       GarbleIdx = 8'(GARBLE_IDX);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  state_t           r_state_q, r_state_d;
  fault_mode_t      r_mode_q, r_mode_d;
  logic [CNT_W-1:0] r_pending_q, r_pending_d;
  logic [CNT_W-1:0] r_injected_q, r_injected_d;
  logic [7:0]       r_idx_q, r_idx_d;
  logic             r_nak_eop_q, r_nak_eop_d;
  logic             r_orphan_q, r_orphan_d;

  logic       w_free;
  logic       w_in_ready;
  logic       w_acc;
  logic       w_elig;
  state_t     w_target;
  logic       w_load;
  logic [7:0] w_ld_data;
  logic       w_ld_sop;
  logic       w_ld_eop;

  assign w_acc = i_in_valid && w_in_ready;

  // Eligibility and destination state for an SOP, judged against the current program.
  always_comb begin
    w_elig   = 1'b0;
    w_target = StPass;
    if (r_pending_q != '0) begin
      unique case (r_mode_q)
        ModeGarble: w_elig = is_data_pid(i_in_data);
        ModeDrop:   w_elig = 1'b1;
        ModeNak:    w_elig = is_data_pid(i_in_data) || (i_in_data == PID_ACK);
        default:    w_elig = 1'b0;
      endcase
    end
    if (w_elig) begin
      unique case (r_mode_q)
        ModeGarble: w_target = StGarble;
        ModeDrop:   w_target = StDrop;
        ModeNak:    w_target = StNakEmit;
        default:    w_target = StPass;
      endcase
    end
  end

  // Consuming states only need the output register when a new SOP may need to pass.
  always_comb begin
    w_in_ready = 1'b0;
    unique case (r_state_q)
      StIdle, StPass, StGarble: w_in_ready = w_free;
      StDrop, StDiscard:        w_in_ready = w_free || !i_in_sop;
      StNakEmit:                w_in_ready = 1'b0;
      default:                  w_in_ready = 1'b0;
    endcase
    if (i_rst) begin
      w_in_ready = 1'b0;
    end
  end

  always_comb begin
    r_state_d    = r_state_q;
    r_mode_d     = r_mode_q;
    r_pending_d  = r_pending_q;
    r_injected_d = r_injected_q;
    r_idx_d      = r_idx_q;
    r_nak_eop_d  = r_nak_eop_q;
    r_orphan_d   = 1'b0;
    w_load       = 1'b0;
    w_ld_data    = i_in_data;
    w_ld_sop     = i_in_sop;
    w_ld_eop     = i_in_eop;

    if (w_acc && i_in_sop) begin
      // An SOP in any state starts a fresh packet, truncating any packet in progress.
      r_state_d = w_target;
      r_idx_d   = 8'd1;
      unique case (w_target)
        StPass: begin
          w_load = 1'b1;
          if (i_in_eop) r_state_d = StIdle;
        end
        StGarble: begin
          w_load = 1'b1;
          if (GarbleIdx == 8'd0) w_ld_data = i_in_data ^ GARBLE_MASK;
          if (i_in_eop) r_state_d = StIdle;
        end
        StDrop: begin
          if (i_in_eop) r_state_d = StIdle;
        end
        StNakEmit: r_nak_eop_d = i_in_eop;
        default: ;
      endcase
      if (w_elig) begin
        r_pending_d  = r_pending_q - 1'b1;
        r_injected_d = (r_injected_q == CntMax) ? r_injected_q : r_injected_q + 1'b1;
      end
    end else if (w_acc) begin
      unique case (r_state_q)
        StIdle: r_orphan_d = 1'b1;
        StPass: begin
          w_load = 1'b1;
          if (i_in_eop) r_state_d = StIdle;
        end
        StGarble: begin
          w_load = 1'b1;
          if (r_idx_q == GarbleIdx) w_ld_data = i_in_data ^ GARBLE_MASK;
          if (r_idx_q != 8'hFF) r_idx_d = r_idx_q + 8'd1;
          if (i_in_eop) r_state_d = StIdle;
        end
        StDrop, StDiscard: begin
          if (i_in_eop) r_state_d = StIdle;
        end
        default: ;
      endcase
    end

    if (r_state_q == StNakEmit && w_free) begin
      w_load    = 1'b1;
      w_ld_data = PID_NAK;
      w_ld_sop  = 1'b1;
      w_ld_eop  = 1'b1;
      r_state_d = r_nak_eop_q ? StIdle : StDiscard;
    end

    // A new program overrides any decrement taken in the same cycle.
    if (i_arm_valid) begin
      r_mode_d    = fault_mode_t'(i_arm_mode);
      r_pending_d = i_arm_count;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state_q    <= StIdle;
      r_mode_q     <= ModeNone;
      r_pending_q  <= '0;
      r_injected_q <= '0;
      r_idx_q      <= 8'd0;
      r_nak_eop_q  <= 1'b0;
      r_orphan_q   <= 1'b0;
    end else begin
      r_state_q    <= r_state_d;
      r_mode_q     <= r_mode_d;
      r_pending_q  <= r_pending_d;
      r_injected_q <= r_injected_d;
      r_idx_q      <= r_idx_d;
      r_nak_eop_q  <= r_nak_eop_d;
      r_orphan_q   <= r_orphan_d;
    end
  end

  usb_byte_out_reg u_out_reg (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_data  (w_ld_data),
    .i_sop   (w_ld_sop),
    .i_eop   (w_ld_eop),
    .i_ready (i_out_ready),
    .o_valid (o_out_valid),
    .o_data  (o_out_data),
    .o_sop   (o_out_sop),
    .o_eop   (o_out_eop),
    .o_free  (w_free)
  );

  assign o_in_ready        = w_in_ready;
  assign o_faults_pending  = r_pending_q;
  assign o_faults_injected = r_injected_q;
  assign o_orphan_err      = r_orphan_q;

endmodule
